// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the hoist PWM ramp sequencer.
// Control word layout: [0] enable, [2:1] prescale, [4:3] mode.
package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_HOLD  = 3'd2,
    S_DEAD  = 3'd3,
    S_ESTOP = 3'd4
  } state_e;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_FWD = 2'b01;
  localparam logic [1:0] MODE_REV = 2'b10;

  localparam int CTL_EN   = 0;
  localparam int CTL_PS   = 1;
  localparam int CTL_MODE = 3;

  function automatic logic [4:0] make_control(
    input logic       en,
    input logic [1:0] prescale,
    input logic [1:0] mode
  );
    logic [4:0] c;
    c = '0;
    c[CTL_EN]       = en;
    c[CTL_PS+:2]    = prescale;
    c[CTL_MODE+:2]  = mode;
    return c;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command handshake into the ramp sequencer.
// Master issues direction + target, slave answers with ready.
interface pwm_ramp_ctrl_if #(
  parameter int DUTY_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [DUTY_W-1:0] cmd_target;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_target,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_target,
    output cmd_ready
  );
endinterface

// File: rtl/ramp_ticker.sv
// Free-running modulo-DIV divider with synchronous clear.
// tick is high for the single cycle where the count is DIV-1.
module ramp_ticker #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/stop sequencer for the hoist PWM: linear duty ramps,
// ramp-to-zero plus dead time before reversal, estop override.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int         DUTY_W   = 10,
  parameter int         DUTY_MAX = 1000,
  parameter int         STEP     = 4,
  parameter int         RAMP_DIV = 1000,
  parameter int         DEAD_CYC = 100,
  parameter logic [1:0] PRESCALE = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  pwm_ramp_ctrl_if.slave    cmd,
  input  logic              estop,
  output logic [4:0]        control,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              done
);
  localparam logic [DUTY_W-1:0] MAXV  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] STEPV = DUTY_W'(STEP);

  state_e            st_q, st_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] ptgt_q, ptgt_d;
  logic              dir_q, dir_d;
  logic              pdir_q, pdir_d;
  logic              pend_q, pend_d;
  logic [4:0]        ctl_q, ctl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic [DUTY_W-1:0] tgt_c;
  logic [DUTY_W-1:0] diff;
  logic [DUTY_W-1:0] stepped;
  logic              up;
  logic              rtick;
  logic              dtick;

  ramp_ticker #(.DIV(RAMP_DIV)) u_ramp (
    .clk   (clk),
    .reset (reset),
    .clr   (st_q != S_RAMP),
    .tick  (rtick)
  );

  ramp_ticker #(.DIV(DEAD_CYC)) u_dead (
    .clk   (clk),
    .reset (reset),
    .clr   (st_q != S_DEAD),
    .tick  (dtick)
  );

  assign cmd.cmd_ready = (st_q == S_IDLE || st_q == S_HOLD)
                       && !estop;
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign tgt_c  = (cmd.cmd_target > MAXV) ? MAXV
                                          : cmd.cmd_target;

  // Saturating step toward tgt_q; never overshoots.
  always_comb begin
    up      = duty_q < tgt_q;
    diff    = up ? (tgt_q - duty_q) : (duty_q - tgt_q);
    stepped = tgt_q;
    if (diff > STEPV)
      stepped = up ? (duty_q + STEPV) : (duty_q - STEPV);
  end

  always_comb begin
    st_d   = st_q;
    duty_d = duty_q;
    tgt_d  = tgt_q;
    dir_d  = dir_q;
    pend_d = pend_q;
    pdir_d = pdir_q;
    ptgt_d = ptgt_q;
    done_d = 1'b0;
    if (estop) begin
      st_d   = S_ESTOP;
      duty_d = '0;
      tgt_d  = '0;
      pend_d = 1'b0;
      ptgt_d = '0;
    end else begin
      unique case (st_q)
        S_IDLE, S_HOLD: begin
          if (accept) begin
            st_d = S_RAMP;
            if (cmd.cmd_dir == dir_q || duty_q == '0) begin
              dir_d  = cmd.cmd_dir;
              tgt_d  = tgt_c;
              pend_d = 1'b0;
            end else begin
              pend_d = 1'b1;
              pdir_d = cmd.cmd_dir;
              ptgt_d = tgt_c;
              tgt_d  = '0;
            end
          end
        end
        S_RAMP: begin
          if (duty_q == tgt_q) begin
            if (tgt_q != '0) begin
              done_d = 1'b1;
              st_d   = S_HOLD;
            end else if (pend_q) begin
              st_d = S_DEAD;
            end else begin
              done_d = 1'b1;
              st_d   = S_IDLE;
            end
          end else if (rtick) begin
            duty_d = stepped;
          end
        end
        S_DEAD: begin
          if (dtick) begin
            if (pend_q) begin
              st_d   = S_RAMP;
              dir_d  = pdir_q;
              tgt_d  = ptgt_q;
              pend_d = 1'b0;
            end else begin
              st_d = S_IDLE;
            end
          end
        end
        S_ESTOP: st_d = S_DEAD;
        default: st_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = !(st_d == S_IDLE || st_d == S_HOLD);
    ctl_d  = '0;
    if ((st_d == S_RAMP || st_d == S_HOLD)
        && (duty_d != '0 || tgt_d != '0))
      ctl_d = make_control(1'b1, PRESCALE,
                           dir_d ? MODE_REV : MODE_FWD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= S_IDLE;
      duty_q <= '0;
      tgt_q  <= '0;
      dir_q  <= 1'b0;
      pend_q <= 1'b0;
      pdir_q <= 1'b0;
      ptgt_q <= '0;
      ctl_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      duty_q <= duty_d;
      tgt_q  <= tgt_d;
      dir_q  <= dir_d;
      pend_q <= pend_d;
      pdir_q <= pdir_d;
      ptgt_q <= ptgt_d;
      ctl_q  <= ctl_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign control    = ctl_q;
  assign duty_cycle = duty_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule
